// File: rtl/warp_issue_sched_pkg.sv
// Shared types and defaults for the warp issue scheduler.
// FSM state encoding and default sizing live here.
package sp_sched_pkg;

   localparam int N_WARP_DEF  = 4;
   localparam int CREDITS_DEF = 2;
   localparam int WARP_W      = $clog2(N_WARP_DEF);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } state_t;

endpackage

// File: rtl/warp_issue_sched_if.sv
// Request/issue/credit bundle between warps, scheduler and unit.
// master = scheduler side, slave = warps plus execution unit.
interface warp_issue_sched_if #(
   parameter int N_WARP  = sp_sched_pkg::N_WARP_DEF,
   parameter int CREDITS = sp_sched_pkg::CREDITS_DEF
);

   localparam int WW = $clog2(N_WARP);
   localparam int CW = $clog2(CREDITS + 1);

   logic [N_WARP-1:0] req_valid;
   logic [N_WARP-1:0] req_ack;
   logic              issue_valid;
   logic [WW-1:0]     issue_warp;
   logic              issue_ready;
   logic              complete;
   logic [CW-1:0]     credit_cnt;
   logic              credit_err;

   modport master (
      input  req_valid,
      input  issue_ready,
      input  complete,
      output req_ack,
      output issue_valid,
      output issue_warp,
      output credit_cnt,
      output credit_err
   );

   modport slave (
      output req_valid,
      output issue_ready,
      output complete,
      input  req_ack,
      input  issue_valid,
      input  issue_warp,
      input  credit_cnt,
      input  credit_err
   );

endinterface

// File: rtl/warp_issue_sched_rr_pick.sv
// Round-robin picker: first set bit of mask at or after start,
// wrapping around; purely combinational.
module rr_pick #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] index
);

   logic [W-1:0] idx;

   // scan N positions from start, index wraps naturally at W bits
   always_comb begin
      found = 1'b0;
      index = '0;
      idx   = '0;
      for (int i = 0; i < N; i++) begin
         idx = start + W'(i);
         if (!found && mask[idx]) begin
            found = 1'b1;
            index = idx;
         end
      end
   end

endmodule

// File: rtl/warp_issue_sched.sv
// Credit-gated round-robin issue scheduler for N_WARP warps
// feeding one shared execution unit.
module warp_issue_sched
   import sp_sched_pkg::*;
#(
   parameter int N_WARP  = N_WARP_DEF,
   parameter int CREDITS = CREDITS_DEF
) (
   input logic               clk,
   input logic               rst_n,
   warp_issue_sched_if.master bus
);

   localparam int WW = $clog2(N_WARP);
   localparam int CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

   state_t            state_q;
   state_t            state_d;
   logic [WW-1:0]     warp_q;
   logic [WW-1:0]     warp_d;
   logic [WW-1:0]     last_q;
   logic [CW-1:0]     cnt_q;
   logic [CW-1:0]     cnt_d;
   logic              err_q;

   logic              fire;
   logic [N_WARP-1:0] warp_bit;
   logic [N_WARP-1:0] elig;
   logic [WW-1:0]     start;
   logic              found;
   logic [WW-1:0]     pick;
   logic              avail_ok;

   assign fire     = (state_q == ST_ISSUE) & bus.issue_ready;
   assign warp_bit = N_WARP'(1) << warp_q;

   // the firing warp is excluded so it cannot win again this cycle
   assign elig  = bus.req_valid & ~(fire ? warp_bit : '0);
   assign start = (fire ? warp_q : last_q) + WW'(1);

   rr_pick #(
      .N (N_WARP),
      .W (WW)
   ) u_pick (
      .mask  (elig),
      .start (start),
      .found (found),
      .index (pick)
   );

   // next credit count, clamped to [0, CREDITS]
   always_comb begin
      cnt_d = cnt_q;
      if (fire && !bus.complete) begin
         if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      end else if (!fire && bus.complete) begin
         if (cnt_q != CRED_MAX) cnt_d = cnt_q + CW'(1);
      end
   end

   assign avail_ok = (cnt_d != '0);

   // next state and next presented warp
   always_comb begin
      state_d = state_q;
      warp_d  = warp_q;
      unique case (state_q)
         ST_IDLE: begin
            if (found && avail_ok) begin
               state_d = ST_ISSUE;
               warp_d  = pick;
            end
         end
         ST_ISSUE: begin
            if (fire) begin
               if (found && avail_ok) begin
                  warp_d = pick;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, issue slot, round-robin pointer, credits, sticky error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         warp_q  <= '0;
         last_q  <= WW'(N_WARP - 1);
         cnt_q   <= CRED_MAX;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         warp_q  <= warp_d;
         cnt_q   <= cnt_d;
         if (fire) last_q <= warp_q;
         if (bus.complete && !fire && cnt_q == CRED_MAX)
            err_q <= 1'b1;
      end
   end

   assign bus.issue_valid = (state_q == ST_ISSUE);
   assign bus.issue_warp  = warp_q;
   assign bus.req_ack     = fire ? warp_bit : '0;
   assign bus.credit_cnt  = cnt_q;
   assign bus.credit_err  = err_q;

endmodule

// File: tb/tb_warp_issue_sched.sv
// Self-checking bench for warp_issue_sched: vector table,
// directed corner sequences and randomized model comparison.
module tb_warp_issue_sched;

   import sp_sched_pkg::*;

   localparam int NW = 4;
   localparam int CR = 2;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   warp_issue_sched_if #(.N_WARP(NW), .CREDITS(CR)) bus ();

   warp_issue_sched #(.N_WARP(NW), .CREDITS(CR)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit       rst;
      bit [3:0] rv;
      bit       rdy;
      bit       cmp;
      int       v;
      int       w;
      int       a;
      int       c;
      int       e;
   } vec_t;

   vec_t tbl[12];

   int m_v, m_w, m_last, m_cred, m_err;

   task automatic chk(input string name, input logic [31:0] act,
                      input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic expect_o(input string tag, input int v, input int w,
                           input int a, input int c, input int e);
      chk({tag, ".valid"}, 32'(bus.issue_valid), v);
      if (v != 0) chk({tag, ".warp"}, 32'(bus.issue_warp), w);
      chk({tag, ".ack"}, 32'(bus.req_ack), a);
      chk({tag, ".cnt"}, 32'(bus.credit_cnt), c);
      chk({tag, ".err"}, 32'(bus.credit_err), e);
   endtask

   task automatic drive(input bit [3:0] rv, input bit rdy, input bit cmp);
      @(negedge clk);
      bus.req_valid   = rv;
      bus.issue_ready = rdy;
      bus.complete    = cmp;
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n           = 1'b0;
      bus.req_valid   = '0;
      bus.issue_ready = 1'b0;
      bus.complete    = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic m_reset();
      m_v    = 0;
      m_w    = 0;
      m_last = NW - 1;
      m_cred = CR;
      m_err  = 0;
   endtask

   // reference: one clock of the scheduling rules in plain arithmetic
   task automatic m_step(input bit [3:0] rv, input bit rdy, input bit cmp);
      int  f;
      int  idx;
      int  nw;
      bit  hit;
      f = (m_v != 0 && rdy) ? 1 : 0;
      if (cmp && f == 0 && m_cred == CR) m_err = 1;
      m_cred = m_cred - f + int'(cmp);
      if (m_cred > CR) m_cred = CR;
      if (m_cred < 0) m_cred = 0;
      if (f != 0) m_last = m_w;
      if (m_v == 0 || f != 0) begin
         hit = 0;
         nw  = 0;
         for (int k = 1; k <= NW; k++) begin
            idx = (m_last + k) % NW;
            if (!hit && rv[idx] && !(f != 0 && idx == m_w)) begin
               hit = 1;
               nw  = idx;
            end
         end
         if (hit && m_cred > 0) begin
            m_v = 1;
            m_w = nw;
         end else begin
            m_v = 0;
         end
      end
   endtask

   initial begin
      bit [3:0] pend;
      bit       rdy;
      bit       cmp;
      int       ack;

      rst_n           = 1'b0;
      bus.req_valid   = '0;
      bus.issue_ready = 1'b0;
      bus.complete    = 1'b0;

      // all request, ready and complete every cycle: 0,1,2,3,0
      tbl[0]  = '{1, 4'hF, 1, 1, 0, 0, 0, 2, 0};
      tbl[1]  = '{0, 4'hF, 1, 1, 1, 0, 1, 2, 1};
      tbl[2]  = '{0, 4'hF, 1, 1, 1, 1, 2, 2, 1};
      tbl[3]  = '{0, 4'hF, 1, 1, 1, 2, 4, 2, 1};
      tbl[4]  = '{0, 4'hF, 1, 1, 1, 3, 8, 2, 1};
      tbl[5]  = '{0, 4'hF, 1, 1, 1, 0, 1, 2, 1};
      // warps 0 and 2, unit stalls three cycles
      tbl[6]  = '{1, 4'h5, 0, 0, 0, 0, 0, 2, 0};
      tbl[7]  = '{0, 4'h5, 0, 0, 1, 0, 0, 2, 0};
      tbl[8]  = '{0, 4'h5, 0, 0, 1, 0, 0, 2, 0};
      tbl[9]  = '{0, 4'h5, 0, 0, 1, 0, 0, 2, 0};
      tbl[10] = '{0, 4'h5, 1, 0, 1, 0, 1, 2, 0};
      tbl[11] = '{0, 4'h4, 0, 0, 1, 2, 0, 1, 0};

      do_reset();
      expect_o("reset", 0, 0, 0, 2, 0);

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].rst) do_reset();
         drive(tbl[i].rv, tbl[i].rdy, tbl[i].cmp);
         expect_o($sformatf("vec%0d", i), tbl[i].v, tbl[i].w,
                  tbl[i].a, tbl[i].c, tbl[i].e);
      end

      // credit exhaustion, then a single complete releases warp 2
      do_reset();
      drive(4'hF, 1, 0); expect_o("cred0", 0, 0, 0, 2, 0);
      drive(4'hF, 1, 0); expect_o("cred1", 1, 0, 1, 2, 0);
      drive(4'hE, 1, 0); expect_o("cred2", 1, 1, 2, 1, 0);
      drive(4'hC, 1, 0); expect_o("cred3", 0, 0, 0, 0, 0);
      drive(4'hC, 1, 1); expect_o("cred4", 0, 0, 0, 0, 0);
      drive(4'hC, 0, 0); expect_o("cred5", 1, 2, 0, 1, 0);

      // spurious complete at full credit is sticky until reset
      do_reset();
      drive(4'h0, 0, 1); expect_o("err0", 0, 0, 0, 2, 0);
      drive(4'h0, 0, 0); expect_o("err1", 0, 0, 0, 2, 1);
      drive(4'h0, 0, 0); expect_o("err2", 0, 0, 0, 2, 1);
      do_reset();
      drive(4'h0, 0, 0); expect_o("err3", 0, 0, 0, 2, 0);

      // fire plus complete at one credit keeps issuing
      do_reset();
      drive(4'h3, 0, 0); expect_o("fc0", 0, 0, 0, 2, 0);
      drive(4'h3, 1, 0); expect_o("fc1", 1, 0, 1, 2, 0);
      drive(4'h6, 1, 1); expect_o("fc2", 1, 1, 2, 1, 0);
      drive(4'h4, 0, 0); expect_o("fc3", 1, 2, 0, 1, 0);

      // reset while an issue is held discards it
      do_reset();
      drive(4'h6, 1, 0); expect_o("rs0", 0, 0, 0, 2, 0);
      drive(4'h6, 1, 0); expect_o("rs1", 1, 1, 2, 2, 0);
      drive(4'h4, 0, 0); expect_o("rs2", 1, 2, 0, 1, 0);
      rst_n = 1'b0;
      bus.issue_ready = 1'b1;
      #1;
      expect_o("rs3", 0, 0, 0, 2, 0);
      @(negedge clk);
      bus.req_valid = '0;
      rst_n = 1'b1;
      drive(4'h6, 0, 0); expect_o("rs4", 0, 0, 0, 2, 0);
      drive(4'h6, 0, 0); expect_o("rs5", 1, 1, 0, 2, 0);

      // randomized traffic against the reference model
      do_reset();
      m_reset();
      pend = '0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
            m_reset();
            pend = '0;
         end
         pend = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0)
            pend = pend & 4'($urandom_range(0, 15));
         rdy = ($urandom_range(0, 9) < 7);
         cmp = ($urandom_range(0, 9) < 3);
         drive(pend, rdy, cmp);
         ack = (m_v != 0 && rdy) ? (1 << m_w) : 0;
         expect_o("rnd", m_v, m_w, ack, m_cred, m_err);
         m_step(pend, rdy, cmp);
         pend = pend & ~4'(ack);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/warp_issue_sched.md
WARP_ISSUE_SCHED -- requirements
Module: warp_issue_sched

Interface
REQ-001 Parameter N_WARP, default 4, number of requesting warps (power of two, >=2).
REQ-002 Parameter CREDITS, default 2, maximum outstanding issues accepted by the shared execution unit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 req_valid  input  N_WARP  per-warp issue request, level.
REQ-006 req_ack  output  N_WARP  one-hot acceptance pulse to the warp whose issue fired.
REQ-007 issue_valid  output  1  registered; an issue is presented to the unit.
REQ-008 issue_warp  output  $clog2(N_WARP)  registered; index of the presented warp.
REQ-009 issue_ready  input  1  unit accepts; fire = issue_valid & issue_ready.
REQ-010 complete  input  1  unit returns one credit this cycle.
REQ-011 credit_cnt  output  $clog2(CREDITS+1)  registered; available credits.
REQ-012 credit_err  output  1  sticky; complete seen with credit_cnt==CREDITS.

Function
REQ-013 FSM has two states: IDLE (issue_valid=0) and ISSUE (issue_valid=1).
REQ-014 Eligible set = req_valid masked by bit issue_warp on a fire cycle; avail = credit_cnt - fire + complete (saturating at CREDITS).
REQ-015 IDLE -> ISSUE when eligible set non-zero and avail>0; else stay IDLE.
REQ-016 Winner = first eligible index scanning from (last_idx+1) mod N_WARP upward with wrap; last_idx resets to N_WARP-1 so warp 0 wins first.
REQ-017 Winner is registered into issue_warp; latency req_valid -> issue_valid is 1 cycle.
REQ-018 In ISSUE without fire, issue_valid and issue_warp hold stable; no re-arbitration.
REQ-019 Requesters keep req_valid high until req_ack; the scheduler does not withdraw a held issue if a requester drops it.
REQ-020 On fire: req_ack[issue_warp]=1 combinationally that cycle; last_idx <= issue_warp; credit consumed.
REQ-021 On fire, same-cycle re-arbitration: stay ISSUE with new winner if eligible and avail>0, else -> IDLE; back-to-back throughput 1 issue/cycle.
REQ-022 req_ack is zero whenever fire is 0.
REQ-023 credit_cnt next = credit_cnt - fire + complete; fire and complete together leave it unchanged.
REQ-024 complete with credit_cnt==CREDITS and no fire: count unchanged, credit_err set until reset.
REQ-025 Never enter or remain in ISSUE with a new winner when avail==0; a held issue (REQ-018) persists even if its credit is already reserved.
REQ-026 All counter arithmetic done at $clog2(CREDITS+1) bits; no wrap below 0 or above CREDITS.

Reset
REQ-027 rst_n low forces asynchronously: state IDLE, issue_valid 0, issue_warp 0, last_idx N_WARP-1, credit_cnt CREDITS, credit_err 0.
REQ-028 Reset asserted mid-ISSUE discards the held issue with no req_ack; outstanding credits are restored to CREDITS.
REQ-029 First arbitration is possible on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package sp_sched_pkg holds the FSM state enum, default N_WARP and CREDITS constants, and the warp-index width.
REQ-031 One sub-module rr_pick: combinational rotate/find-first-set picker (inputs mask, start index; outputs found, index), instantiated once.
REQ-032 All registers live in warp_issue_sched; rr_pick holds no state.

Verification
REQ-033 req_valid=4'b1111 steady, issue_ready=1, complete=1 every cycle -> issue_warp 0,1,2,3,0,... on consecutive cycles, issue_valid continuously 1.
REQ-034 req_valid=4'b0101, issue_ready=0 for 3 cycles then 1 -> issue_warp=0 held 4 cycles, req_ack=4'b0001 only on fire cycle, next issue_warp=2.
REQ-035 CREDITS=2, complete=0, all requesting, ready=1 -> two fires (warps 0,1), then issue_valid=0, credit_cnt=0; one complete pulse -> warp 2 issued next cycle.
REQ-036 credit_cnt=2, complete=1 with no fire -> credit_cnt stays 2, credit_err=1 and remains 1 until reset.
REQ-037 credit_cnt=1, fire and complete in same cycle -> credit_cnt stays 1 and the next winner is issued immediately.
REQ-038 rst_n pulsed low while issue_valid=1, ready=0 -> issue_valid=0 immediately, no req_ack, credit_cnt=CREDITS, first issue after release goes to lowest requesting warp.
